// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, mispredict flush and drained interrupt entry; optional HAZ_PERF_CNT_EN perf counters
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 2,
  parameter int INT_DRAIN      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_x_addr,
  input  logic [4:0] id_y_addr,
  input  logic       id_uses_x,
  input  logic       id_uses_y,
  input  logic       ex_rf_wr,
  input  logic [4:0] ex_wb_addr,
  input  logic [1:0] ex_rf_wr_sel,
  input  logic       ex_mispredict,
  input  logic       int_req,
  input  logic       i_flag,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_nop,
  output logic       id_ex_int,
  output logic       int_ack,
  output logic [2:0] state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cyc,
  output logic [15:0] perf_flush_evt,
  output logic [15:0] perf_int_evt
`endif
);
  typedef enum logic [2:0] {RUN, STALL, FLUSH, DRAIN, INJECT} st_t;
  localparam logic [2:0] FL_RUN = 3'(FLUSH_CYCLES - 2);
  localparam logic [2:0] FL_DRN = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_LD  = 3'(LOAD_USE_STALL - 2);
  localparam logic [2:0] ID_LD  = 3'(INT_DRAIN - 1);
  st_t st;
  logic [2:0] cnt;
  logic int_pend, lu, take_int, mp_evt, do_flush, do_stall, do_inj;
  assign state = st;
  // Hazard decode and Mealy output selection; everything is held low during reset
  always_comb begin
    lu = ex_rf_wr & (ex_rf_wr_sel != 2'b00) &
         ((id_uses_x & (id_x_addr == ex_wb_addr)) | (id_uses_y & (id_y_addr == ex_wb_addr)));
    take_int = (int_req | int_pend) & i_flag;
    mp_evt = ex_mispredict & (st == RUN | st == STALL | st == DRAIN);
    do_flush = ~rst & (mp_evt | st == FLUSH);
    do_stall = ~rst & ~do_flush & (st == STALL | st == DRAIN | (st == RUN & (lu | take_int)));
    do_inj = ~rst & (st == INJECT);
    pc_stall = do_stall | do_inj;
    if_id_stall = do_stall;
    if_id_flush = do_flush | do_inj;
    id_ex_nop = do_flush | do_stall;
    id_ex_int = do_inj;
    int_ack = do_inj;
  end
  // State, remaining-cycle counter and deferred interrupt latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN;
      cnt <= '0;
      int_pend <= 1'b0;
    end else begin
      case (st)
        RUN: begin
          if (ex_mispredict) begin
            st <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt <= FL_RUN;
            int_pend <= int_pend | int_req;
          end else if (lu) begin
            st <= LOAD_USE_STALL > 1 ? STALL : RUN;
            cnt <= LU_LD;
            int_pend <= int_pend | int_req;
          end else if (take_int) begin
            st <= INT_DRAIN > 1 ? DRAIN : INJECT;
            cnt <= ID_LD;
          end
        end
        STALL: begin
          if (ex_mispredict) begin
            st <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt <= FL_RUN;
          end else if (cnt == 3'd0) st <= RUN;
          else cnt <= cnt - 3'd1;
        end
        FLUSH: begin
          if (cnt == 3'd0) st <= RUN;
          else cnt <= cnt - 3'd1;
        end
        DRAIN: begin
          if (ex_mispredict) begin
            int_pend <= 1'b1;
            st <= FLUSH;
            cnt <= FL_DRN;
          end else if (cnt <= 3'd1) st <= INJECT;
          else cnt <= cnt - 3'd1;
        end
        INJECT: begin
          int_pend <= 1'b0;
          st <= RUN;
        end
        default: st <= RUN;
      endcase
    end
  end
`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
      perf_int_evt <= '0;
    end else begin
      if (id_ex_nop && perf_stall_cyc != 16'hFFFF) perf_stall_cyc <= perf_stall_cyc + 16'd1;
      if (mp_evt && perf_flush_evt != 16'hFFFF) perf_flush_evt <= perf_flush_evt + 16'd1;
      if (do_inj && perf_int_evt != 16'hFFFF) perf_int_evt <= perf_int_evt + 16'd1;
    end
  end
`endif
endmodule
